video_sync_decoder: RTL and testbench

VIDEO_SYNC_DECODER -- requirements
Module: video_sync_decoder

---
 rtl/video_sync_decoder.sv | 185 ++++++++++++++++++
 tb/tb_video_sync_decoder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_sync_decoder.sv
// Recovers line/frame timing from active-high sync and blank inputs, measures
// the raster geometry and reports lock, loss of lock and the current position.
module video_sync_decoder (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_pix,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       hbl_in,
    input  logic       vbl_in,
    output logic [8:0] hc_rec,
    output logic [8:0] vc_rec,
    output logic [8:0] h_total,
    output logic [8:0] v_total,
    output logic [8:0] h_active,
    output logic [8:0] v_active,
    output logic       locked,
    output logic       sync_err
);

    typedef enum logic [1:0] {
        SEARCH,
        TRACK,
        LOCKED
    } state_e;

    state_e     state_q, state_d;
    logic       hs_prev_q, hs_prev_d;
    logic       vs_prev_q, vs_prev_d;
    logic [8:0] hcnt_q, hcnt_d;
    logic [8:0] hact_q, hact_d;
    logic [8:0] lcnt_q, lcnt_d;
    logic [8:0] vact_q, vact_d;
    logic [8:0] h_cand_q, h_cand_d;
    logic [8:0] ha_cand_q, ha_cand_d;
    logic [8:0] h_prev_q, h_prev_d;
    logic [8:0] v_prev_q, v_prev_d;
    logic       prev_valid_q, prev_valid_d;
    logic [8:0] h_total_q, h_total_d;
    logic [8:0] v_total_q, v_total_d;
    logic [8:0] h_active_q, h_active_d;
    logic [8:0] v_active_q, v_active_d;
    logic       locked_q, locked_d;
    logic       sync_err_q, sync_err_d;

    logic       hrise;
    logic       vrise;
    logic       hsat;
    logic [8:0] lcnt_inc;
    logic [8:0] vact_inc;
    logic [8:0] v_cand;
    logic [8:0] va_cand;

    always_comb begin
        hrise        = clk_pix & hsync_in & ~hs_prev_q;
        vrise        = clk_pix & vsync_in & ~vs_prev_q;

        state_d      = state_q;
        hs_prev_d    = hs_prev_q;
        vs_prev_d    = vs_prev_q;
        hcnt_d       = hcnt_q;
        hact_d       = hact_q;
        h_cand_d     = h_cand_q;
        ha_cand_d    = ha_cand_q;
        h_prev_d     = h_prev_q;
        v_prev_d     = v_prev_q;
        prev_valid_d = prev_valid_q;
        h_total_d    = h_total_q;
        v_total_d    = v_total_q;
        h_active_d   = h_active_q;
        v_active_d   = v_active_q;
        sync_err_d   = 1'b0;

        // A line start coincident with a frame start is counted before the latch.
        lcnt_inc = (hrise && lcnt_q != '1) ? lcnt_q + 9'd1 : lcnt_q;
        vact_inc = (hrise && !vbl_in && vact_q != '1) ? vact_q + 9'd1 : vact_q;
        v_cand   = lcnt_inc - 9'd1;
        va_cand  = vact_inc;
        lcnt_d   = vrise ? '0 : lcnt_inc;
        vact_d   = vrise ? '0 : vact_inc;

        if (clk_pix) begin
            hs_prev_d = hsync_in;
            vs_prev_d = vsync_in;
            if (hrise) begin
                h_cand_d  = hcnt_q;
                ha_cand_d = hact_q;
                hcnt_d    = '0;
                hact_d    = '0;
            end else begin
                if (hcnt_q != '1) hcnt_d = hcnt_q + 9'd1;
                if (!hbl_in && hact_q != '1) hact_d = hact_q + 9'd1;
            end
        end

        hsat = clk_pix && (hcnt_d == '1);

        unique case (state_q)
            SEARCH: begin
                if (vrise) begin
                    state_d      = TRACK;
                    prev_valid_d = 1'b0;
                end
            end
            TRACK: begin
                if (hsat) begin
                    state_d = SEARCH;
                end else if (vrise) begin
                    if (prev_valid_q && h_cand_d == h_prev_q && v_cand == v_prev_q) begin
                        state_d    = LOCKED;
                        h_total_d  = h_cand_d;
                        v_total_d  = v_cand;
                        h_active_d = ha_cand_d;
                        v_active_d = va_cand;
                    end
                    h_prev_d     = h_cand_d;
                    v_prev_d     = v_cand;
                    prev_valid_d = 1'b1;
                end
            end
            LOCKED: begin
                if (hsat || (hrise && h_cand_d != h_total_q) ||
                    (vrise && v_cand != v_total_q)) begin
                    state_d    = SEARCH;
                    sync_err_d = 1'b1;
                end
            end
            default: state_d = SEARCH;
        endcase

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= SEARCH;
            hs_prev_q    <= 1'b0;
            vs_prev_q    <= 1'b0;
            hcnt_q       <= '0;
            hact_q       <= '0;
            lcnt_q       <= '0;
            vact_q       <= '0;
            h_cand_q     <= '0;
            ha_cand_q    <= '0;
            h_prev_q     <= '0;
            v_prev_q     <= '0;
            prev_valid_q <= 1'b0;
            h_total_q    <= '0;
            v_total_q    <= '0;
            h_active_q   <= '0;
            v_active_q   <= '0;
            locked_q     <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hs_prev_q    <= hs_prev_d;
            vs_prev_q    <= vs_prev_d;
            hcnt_q       <= hcnt_d;
            hact_q       <= hact_d;
            lcnt_q       <= lcnt_d;
            vact_q       <= vact_d;
            h_cand_q     <= h_cand_d;
            ha_cand_q    <= ha_cand_d;
            h_prev_q     <= h_prev_d;
            v_prev_q     <= v_prev_d;
            prev_valid_q <= prev_valid_d;
            h_total_q    <= h_total_d;
            v_total_q    <= v_total_d;
            h_active_q   <= h_active_d;
            v_active_q   <= v_active_d;
            locked_q     <= locked_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign hc_rec   = hcnt_q;
    assign vc_rec   = lcnt_q;
    assign h_total  = h_total_q;
    assign v_total  = v_total_q;
    assign h_active = h_active_q;
    assign v_active = v_active_q;
    assign locked   = locked_q;
    assign sync_err = sync_err_q;

endmodule

// File: tb/tb_video_sync_decoder.sv
// Scoreboard bench for video_sync_decoder: a raster generator with 384-enable
// lines and short 8-line frames drives the sync inputs and queues expectations.
module tb_video_sync_decoder;

    localparam int LINE   = 384;
    localparam int NLINES = 8;
    localparam int HS_ON  = 296;
    localparam int HS_OFF = 327;
    localparam int HBL_ON = 256;
    localparam int EXP_HT = 383;
    localparam int EXP_VT = 7;
    localparam int EXP_HA = 256;
    localparam int EXP_VA = 4;
    localparam int FRAME  = NLINES * LINE;

    localparam int S_LOCK = 0, S_ERR = 1, S_HT = 2, S_VT = 3;
    localparam int S_HA = 4, S_VA = 5, S_HC = 6, S_VC = 7;

    logic       clk = 1'b0;
    logic       reset, clk_pix, hsync_in, vsync_in, hbl_in, vbl_in;
    logic [8:0] hc_rec, vc_rec, h_total, v_total, h_active, v_active;
    logic       locked, sync_err;

    always #5 clk = ~clk;

    video_sync_decoder dut (
        .clk      (clk),
        .reset    (reset),
        .clk_pix  (clk_pix),
        .hsync_in (hsync_in),
        .vsync_in (vsync_in),
        .hbl_in   (hbl_in),
        .vbl_in   (vbl_in),
        .hc_rec   (hc_rec),
        .vc_rec   (vc_rec),
        .h_total  (h_total),
        .v_total  (v_total),
        .h_active (h_active),
        .v_active (v_active),
        .locked   (locked),
        .sync_err (sync_err)
    );

    int    total = 0;
    int    bad   = 0;
    string sb_tag[$];
    int    sb_sel[$];
    int    sb_val[$];

    int ln = 0, px = 0, glitch_ln = -1;
    bit div2 = 1'b0, gate_tog = 1'b0, hs_kill = 1'b0, coinc = 1'b0;
    bit hs_last = 1'b0, vs_last = 1'b0;
    int hc_m = 0, vc_m = 0;
    bit err_on_hr = 1'b0, err_on_sat = 1'b0, err_zero_next = 1'b0, watch_on = 1'b0;
    int vr_seen = 0;
    int err_exp = 0, err_seen = 0;

    always @(negedge clk) if (sync_err === 1'b1) err_seen++;

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int observe(input int sel);
        case (sel)
            S_LOCK:  observe = int'(locked);
            S_ERR:   observe = int'(sync_err);
            S_HT:    observe = int'(h_total);
            S_VT:    observe = int'(v_total);
            S_HA:    observe = int'(h_active);
            S_VA:    observe = int'(v_active);
            S_HC:    observe = int'(hc_rec);
            S_VC:    observe = int'(vc_rec);
            default: observe = -1;
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input int val);
        sb_tag.push_back(tag);
        sb_sel.push_back(sel);
        sb_val.push_back(val);
    endtask

    task automatic push_err(input string tag);
        push({tag, "_sync_err"}, S_ERR, 1);
        push({tag, "_locked"}, S_LOCK, 0);
        push({tag, "_h_total_held"}, S_HT, EXP_HT);
        err_exp++;
        err_zero_next = 1'b1;
    endtask

    task automatic fire();
        string t;
        int    s, v;
        @(posedge clk);
        #1;
        while (sb_val.size() > 0) begin
            t = sb_tag.pop_front();
            s = sb_sel.pop_front();
            v = sb_val.pop_front();
            check_val(t, observe(s), v);
        end
    endtask

    // One pixel enable: drive the raster, queue what the DUT must show after it.
    task automatic run_en();
        bit hs, vs, hr, vr;
        hs = !hs_kill && px >= HS_ON && px <= HS_OFF;
        if (coinc) vs = (ln == 5 && px >= HS_ON) || ln == 6 || (ln == 7 && px < HS_ON);
        else       vs = (ln == 5) || (ln == 6);
        hsync_in = hs;
        vsync_in = vs;
        hbl_in   = (px >= HBL_ON);
        vbl_in   = (ln >= 4);
        clk_pix  = 1'b1;
        hr = hs && !hs_last;
        vr = vs && !vs_last;
        hs_last = hs;
        vs_last = vs;
        hc_m = hr ? 0 : ((hc_m == 511) ? 511 : hc_m + 1);
        if (vr) vc_m = 0;
        else if (hr && vc_m != 511) vc_m++;

        if (err_zero_next) begin
            push("sync_err_one_clk", S_ERR, 0);
            err_zero_next = 1'b0;
        end
        if (err_on_hr && hr) begin
            err_on_hr = 1'b0;
            push_err("glitch");
            watch_on = 1'b1;
            vr_seen  = 0;
        end
        if (err_on_sat && hc_m == 511) begin
            err_on_sat = 1'b0;
            push_err("lost_hsync");
        end
        if (vr) begin
            push("vc_rec_after_vrise", S_VC, 0);
            if (watch_on) begin
                vr_seen++;
                push("locked_at_vrise", S_LOCK, int'(vr_seen >= 3));
                if (vr_seen == 3) begin
                    push("h_total", S_HT, EXP_HT);
                    push("v_total", S_VT, EXP_VT);
                    push("h_active", S_HA, EXP_HA);
                    push("v_active", S_VA, EXP_VA);
                    watch_on = 1'b0;
                end
            end
        end
        if (px == 100) begin
            push("hc_rec", S_HC, hc_m);
            push("vc_rec", S_VC, vc_m);
        end
        fire();

        if (div2) begin
            clk_pix = 1'b0;
            if (gate_tog && !hs) hsync_in = 1'b1;
            @(posedge clk);
            #1;
            hsync_in = hs;
        end

        px++;
        if (px >= ((ln == glitch_ln) ? LINE - 4 : LINE)) begin
            if (ln == glitch_ln) begin
                glitch_ln = -1;
                err_on_hr = 1'b1;
            end
            px = 0;
            ln = (ln + 1) % NLINES;
        end
    endtask

    task automatic run_to(input int l, input int p, input string tag);
        int n = 0;
        while (!(ln == l && px == p) && n < 2 * FRAME) begin
            run_en();
            n++;
        end
        check_val({tag, "_reached"}, int'(ln == l && px == p), 1);
    endtask

    task automatic run_lock(input string tag);
        int n = 0;
        while (watch_on && n < 5 * FRAME) begin
            run_en();
            n++;
        end
        check_val({tag, "_lock_timeout"}, int'(watch_on), 0);
        watch_on = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        reset   = 1'b1;
        clk_pix = 1'b1;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        clk_pix = 1'b0;
        hs_last = 1'b0;
        vs_last = 1'b0;
        hc_m    = 0;
        vc_m    = 0;
        for (int s = S_LOCK; s <= S_VC; s++) begin
            check_val($sformatf("%s_out%0d_zero", tag, s), observe(s), 0);
        end
    endtask

    initial begin
        reset    = 1'b1;
        clk_pix  = 1'b0;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        hbl_in   = 1'b0;
        vbl_in   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset("por");

        // Nominal acquisition with an enable on every second clock.
        div2     = 1'b1;
        watch_on = 1'b1;
        vr_seen  = 0;
        run_lock("nominal");

        // Sync toggles seen only on disabled clocks must be invisible.
        gate_tog = 1'b1;
        run_to(4, 0, "gating");
        gate_tog = 1'b0;
        check_val("gating_locked", int'(locked), 1);
        check_val("gating_err_total", err_seen, err_exp);

        // Remaining phases use a continuous enable.
        div2 = 1'b0;
        run_to(0, 0, "pre_glitch");
        glitch_ln = 1;
        run_to(3, 0, "glitch");
        run_lock("glitch_relock");
        check_val("glitch_err_total", err_seen, err_exp);

        run_to(1, 300, "pre_kill");
        hs_kill    = 1'b1;
        err_on_sat = 1'b1;
        run_to(7, 0, "kill");
        hs_kill = 1'b0;
        check_val("kill_err_total", err_seen, err_exp);
        watch_on = 1'b1;
        vr_seen  = 0;
        run_lock("kill_relock");

        run_to(3, 0, "pre_mid_reset");
        do_reset("mid_reset");
        watch_on = 1'b1;
        vr_seen  = 0;
        run_lock("mid_reset_relock");

        run_to(0, 0, "pre_coinc");
        coinc = 1'b1;
        do_reset("coinc_reset");
        watch_on = 1'b1;
        vr_seen  = 0;
        run_lock("coinc_lock");
        run_to(6, 0, "coinc_hold");
        check_val("coinc_locked", int'(locked), 1);
        check_val("final_err_total", err_seen, err_exp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
